// File: rtl/rv32i_types.sv
// ----------------------------------------------------------------------------
// rv32i_types
//   Shared types for the RV32I out-of-order store path.
//   - TAG_W          : width of ROB tags and CDB reg_id fields (0 = value present)
//   - store_funct3_e : funct3 encodings of the store instructions
//   - command_buffer : one CDB broadcast channel {reg_id, data}
//   - operand_t      : pending-tag / value pair for one source operand
//   - sq_entry_t     : one store queue entry
// ----------------------------------------------------------------------------
package rv32i_types;

    localparam int TAG_W = 5;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_e;

    typedef struct packed {
        logic [TAG_W-1:0] reg_id;
        logic [31:0]      data;
    } command_buffer;

    typedef struct packed {
        logic [TAG_W-1:0] q;
        logic [31:0]      v;
    } operand_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [2:0]       funct3;
        logic [TAG_W-1:0] q1;
        logic [TAG_W-1:0] q2;
        logic [31:0]      v1;
        logic [31:0]      v2;
        logic [31:0]      imm;
    } sq_entry_t;

endpackage

// File: rtl/sq_fwd_select.sv
// ----------------------------------------------------------------------------
// sq_fwd_select
//   Age-ordered priority picker for store-to-load forwarding. Scans the
//   circular queue from the tail backward (youngest first) and stops at the
//   head, returning the youngest set bit of the match vector.
//   Built only when STORE_BUFFER_FWD_EN is defined.
//   Ports:
//     match_i : per-entry match vector
//     head_i  : head (oldest) pointer
//     tail_i  : tail pointer (one past the youngest entry)
//     idx_o   : index of the youngest matching entry
//     hit_o   : at least one entry matched
// ----------------------------------------------------------------------------
`ifdef STORE_BUFFER_FWD_EN
module sq_fwd_select #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] match_i,
    input  logic [PTR_W-1:0] head_i,
    input  logic [PTR_W-1:0] tail_i,
    output logic [PTR_W-1:0] idx_o,
    output logic             hit_o
);

    logic [PTR_W-1:0] scan_idx;
    logic             scan_done;

    always_comb begin
        idx_o     = '0;
        hit_o     = 1'b0;
        scan_idx  = tail_i;
        scan_done = 1'b0;
        // k = DEPTH wraps back to tail, which equals head only when full.
        for (int k = 1; k <= DEPTH; k++) begin
            scan_idx = tail_i - PTR_W'(k);
            if (!scan_done && !hit_o && match_i[scan_idx]) begin
                hit_o = 1'b1;
                idx_o = scan_idx;
            end
            if (scan_idx == head_i) begin
                scan_done = 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/store_buffer.sv
// ----------------------------------------------------------------------------
// store_buffer
//   In-order store queue between the issue queue and the D-cache store port.
//   Holds DEPTH stores whose base/data operands may still be pending tags,
//   captures results from NUM_CDB broadcast channels (including in the cycle
//   of enqueue), and releases the oldest resolved store under valid/ack.
//   Optional macro STORE_BUFFER_FWD_EN enables store-to-load forwarding;
//   without it the fwd_* outputs stall any load while the queue is non-empty.
//   TAG_W must equal rv32i_types::TAG_W (entry and CDB fields are sized by it).
//   Ports:
//     clk, rst, flush                 : clock, sync active-high reset, flush
//     enq_*                           : store from the issue queue
//     cdb_i                           : broadcast channels {reg_id, data}
//     head_valid/head_ack/head_*      : oldest store to memory
//     count, empty                    : occupancy
//     ld_addr_i, fwd_hit/block/data   : forwarding query
// ----------------------------------------------------------------------------
module store_buffer
    import rv32i_types::*;
#(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 4,
    parameter int TAG_W   = rv32i_types::TAG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [TAG_W-1:0]           enq_tag,
    input  logic [2:0]                 enq_funct3,
    input  logic [TAG_W-1:0]           enq_q1,
    input  logic [TAG_W-1:0]           enq_q2,
    input  logic [31:0]                enq_v1,
    input  logic [31:0]                enq_v2,
    input  logic [31:0]                enq_imm,
    input  command_buffer              cdb_i [NUM_CDB],
    output logic                       head_valid,
    input  logic                       head_ack,
    output logic [TAG_W-1:0]           head_tag,
    output logic [2:0]                 head_funct3,
    output logic [31:0]                head_addr,
    output logic [31:0]                head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    input  logic [31:0]                ld_addr_i,
    output logic                       fwd_hit,
    output logic                       fwd_block,
    output logic [31:0]                fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    sq_entry_t        entries_q [DEPTH];
    sq_entry_t        entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    sq_entry_t        head_e;
    logic             enq_fire;
    logic             deq_fire;

    // Resolve one operand against all channels; descending scan lets the
    // lowest matching channel overwrite last. A nonzero q never matches an
    // idle channel (reg_id 0).
    function automatic operand_t resolve(input operand_t op);
        operand_t res;
        res = op;
        if (op.q != '0) begin
            for (int c = NUM_CDB-1; c >= 0; c--) begin
                if (cdb_i[c].reg_id == op.q) begin
                    res.q = '0;
                    res.v = cdb_i[c].data;
                end
            end
        end
        return res;
    endfunction

    assign head_e      = entries_q[head_q];
    assign head_valid  = head_e.valid && (head_e.q1 == '0) && (head_e.q2 == '0);
    assign head_tag    = head_e.tag;
    assign head_funct3 = head_e.funct3;
    assign head_addr   = head_e.v1 + head_e.imm;
    assign head_data   = head_e.v2;
    assign count       = count_q;
    assign empty       = (count_q == '0);
    // No full-bypass: a full queue refuses even when the head leaves this cycle.
    assign enq_ready   = (count_q != CNT_W'(DEPTH));
    assign enq_fire    = enq_valid && enq_ready;
    assign deq_fire    = head_valid && head_ack;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid) begin
                {entries_d[i].q1, entries_d[i].v1} = resolve({entries_q[i].q1, entries_q[i].v1});
                {entries_d[i].q2, entries_d[i].v2} = resolve({entries_q[i].q2, entries_q[i].v2});
            end
        end

        if (deq_fire) begin
            entries_d[head_q] = '0;
            head_d            = head_q + PTR_W'(1);
        end

        // Enqueue and dequeue never target the same slot: enqueue needs a
        // non-full queue, so tail != head whenever the head is valid.
        if (enq_fire) begin
            entries_d[tail_q].valid            = 1'b1;
            entries_d[tail_q].tag              = enq_tag;
            entries_d[tail_q].funct3           = enq_funct3;
            {entries_d[tail_q].q1, entries_d[tail_q].v1} = resolve({enq_q1, enq_v1});
            {entries_d[tail_q].q2, entries_d[tail_q].v2} = resolve({enq_q2, enq_v2});
            entries_d[tail_q].imm              = enq_imm;
            tail_d                             = tail_q + PTR_W'(1);
        end

        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge value; the comb block above uses blocking ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the entry array is reset as well, because head_* outputs
            // read the head slot directly and must be zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    logic [DEPTH-1:0] fwd_match;
    logic             fwd_any_q1;
    logic             fwd_sel_hit;
    logic [PTR_W-1:0] fwd_sel_idx;
    sq_entry_t        fwd_e;

    // Word-granular address compare; any unresolved base makes the store's
    // address unknown, so the load must wait.
    always_comb begin
        fwd_match  = '0;
        fwd_any_q1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_match[i] = entries_q[i].valid &&
                           (((entries_q[i].v1 + entries_q[i].imm) >> 2) == (ld_addr_i >> 2));
            fwd_any_q1   = fwd_any_q1 || (entries_q[i].valid && (entries_q[i].q1 != '0));
        end
    end

    sq_fwd_select #(
        .DEPTH (DEPTH)
    ) u_fwd_select (
        .match_i (fwd_match),
        .head_i  (head_q),
        .tail_i  (tail_q),
        .idx_o   (fwd_sel_idx),
        .hit_o   (fwd_sel_hit)
    );

    assign fwd_e     = entries_q[fwd_sel_idx];
    assign fwd_block = fwd_any_q1 ||
                       (fwd_sel_hit && ((fwd_e.funct3 != SW) || (fwd_e.q2 != '0)));
    assign fwd_hit   = fwd_sel_hit && !fwd_block;
    assign fwd_data  = fwd_hit ? fwd_e.v2 : '0;
`else
    logic unused_ld_addr;
    assign unused_ld_addr = ^ld_addr_i;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
    assign fwd_block      = !empty;
`endif

endmodule
